// File: rtl/spi_link_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : spi_link_pkg                                                    |
// | Purpose : Shared defaults and link-state type for the SPI byte link.      |
// | Contents: c_DATA_W_DEFAULT    - bits per SPI word                         |
// |           c_IDLE_BYTE_DEFAULT - byte shifted out when nothing is buffered |
// |           link_state_t        - IDLE (cs high) / ACTIVE (cs low)          |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package spi_link_pkg;

   localparam int         c_DATA_W_DEFAULT    = 8;
   localparam logic [7:0] c_IDLE_BYTE_DEFAULT = 8'h00;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } link_state_t;

endpackage : spi_link_pkg
`default_nettype wire

// File: rtl/spi_byte_link_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: spi_byte_link_if                                               |
// | Purpose  : Bundles the SPI pins and the byte-level core handshake.        |
// | Signals  : spi_clk, cs, mosi, miso       - SPI pins (mode 0, MSB first)   |
// |            rx_data, rx_valid             - received word to the core      |
// |            frame_start/end/abort         - frame boundary pulses          |
// |            tx_data, tx_valid, tx_ready   - word from the core for MISO    |
// |            tx_underrun                   - idle byte had to be loaded     |
// | Modports : slave  - the link itself                                       |
// |            master - pin driver and core side                              |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface spi_byte_link_if #(
   parameter int DATA_W = spi_link_pkg::c_DATA_W_DEFAULT
);

   logic              spi_clk;
   logic              cs;
   logic              mosi;
   logic              miso;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_start;
   logic              frame_end;
   logic              frame_abort;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_underrun;

   modport slave (
      input  spi_clk, cs, mosi, tx_data, tx_valid,
      output miso, rx_data, rx_valid, frame_start, frame_end, frame_abort,
             tx_ready, tx_underrun
   );

   modport master (
      output spi_clk, cs, mosi, tx_data, tx_valid,
      input  miso, rx_data, rx_valid, frame_start, frame_end, frame_abort,
             tx_ready, tx_underrun
   );

endinterface : spi_byte_link_if
`default_nettype wire

// File: rtl/sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sync_edge                                                       |
// | Purpose : Brings an asynchronous pin into the clk domain through a        |
// |           SYNC_STAGES flop chain and flags its rising/falling edges       |
// |           against one extra history flop.                                 |
// | Ports   : clk, rst_n  - system clock, async active-low reset              |
// |           i_async     - asynchronous input pin                            |
// |           o_rise      - 1-cycle pulse, synchronised 0->1                  |
// |           o_fall      - 1-cycle pulse, synchronised 1->0                  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
)(
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_async,
   output logic      o_rise,
   output logic      o_fall
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_prev;
   logic                   w_sync;

   // Chain and history both reset to the pin's idle level so that leaving
   // reset never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= {SYNC_STAGES{RESET_VAL}};
         r_prev  <= RESET_VAL;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
         r_prev  <= w_sync;
      end
   end

   assign w_sync = r_chain[SYNC_STAGES-1];
   assign o_rise = w_sync & ~r_prev;
   assign o_fall = ~w_sync & r_prev;

endmodule : sync_edge
`default_nettype wire

// File: rtl/spi_byte_link.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : spi_byte_link                                                   |
// | Purpose : SPI slave front end (mode 0, MSB first). Synchronises the pins  |
// |           into clk, deserialises MOSI into words for the core and         |
// |           serialises core words onto MISO through a one-word holding      |
// |           buffer.                                                         |
// | Ports   : clk    - system clock, rising edge                              |
// |           rst_n  - asynchronous active-low reset                          |
// |           bus    - spi_byte_link_if.slave (pins + core handshake)         |
// | Params  : SYNC_STAGES - synchroniser depth (>= 2)                         |
// |           DATA_W      - bits per SPI word                                 |
// |           IDLE_BYTE   - word sent when the buffer is empty at a boundary  |
// | Note    : spi_clk must be at most clk/8.                                  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module spi_byte_link
   import spi_link_pkg::*;
#(
   parameter int                SYNC_STAGES = 2,
   parameter int                DATA_W      = c_DATA_W_DEFAULT,
   parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(c_IDLE_BYTE_DEFAULT)
)(
   input  wire logic      clk,
   input  wire logic      rst_n,
   spi_byte_link_if.slave bus
);

   localparam int                 c_CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);

   // ---------------------------------------------------------------- sync
   logic                   w_sck_rise;
   logic                   w_sck_fall;
   logic                   w_cs_rise;
   logic                   w_cs_fall;
   logic [SYNC_STAGES-1:0] r_mosi_chain;
   logic                   w_mosi_sync;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
   ) u_sync_sck (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (bus.spi_clk),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   // cs idles high, so its chain resets to 1.
   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b1)
   ) u_sync_cs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (bus.cs),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   // MOSI has the same depth as spi_clk, so the synchronised data bit lines
   // up with the synchronised clock edge that samples it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mosi_chain <= '0;
      end else begin
         r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], bus.mosi};
      end
   end

   assign w_mosi_sync = r_mosi_chain[SYNC_STAGES-1];

   // ------------------------------------------------------------- state
   link_state_t        r_state;
   logic [c_CNT_W-1:0] r_bit_cnt;
   logic [DATA_W-2:0]  r_rx_shift;
   logic [DATA_W-1:0]  r_rx_data;
   logic               r_rx_valid;
   logic               r_frame_start;
   logic               r_frame_end;
   logic               r_frame_abort;
   logic [DATA_W-1:0]  r_tx_shift;
   logic               r_miso;
   logic [DATA_W-1:0]  r_buf;
   logic               r_buf_full;
   logic               r_tx_ready;
   logic               r_tx_underrun;

   logic               w_cs_fall_evt;
   logic               w_cs_rise_evt;
   logic               w_sck_rise_evt;
   logic               w_sck_fall_evt;
   logic               w_reload;
   logic [DATA_W-1:0]  w_load_word;
   logic               w_accept;
   logic               w_full_next;
   logic [DATA_W-1:0]  w_rx_word;

   always_comb begin
      // SPI clock edges only count while a frame is open; a cs rise in the
      // same cycle closes the frame and wins over any clock edge.
      w_cs_fall_evt  = (r_state == ST_IDLE)   && w_cs_fall;
      w_cs_rise_evt  = (r_state == ST_ACTIVE) && w_cs_rise;
      w_sck_rise_evt = (r_state == ST_ACTIVE) && !w_cs_rise && w_sck_rise;
      w_sck_fall_evt = (r_state == ST_ACTIVE) && !w_cs_rise && w_sck_fall;

      // A falling edge with bit_cnt==0 means the previous word has been fully
      // sampled by the master: time to present the next one.
      w_reload    = w_cs_fall_evt || (w_sck_fall_evt && (r_bit_cnt == '0));
      w_load_word = r_buf_full ? r_buf : IDLE_BYTE;

      // Accept only into an empty buffer; a reload in the same cycle takes
      // the old content (or IDLE_BYTE) and the new word still lands.
      w_accept    = bus.tx_valid && r_tx_ready;
      w_full_next = w_accept || (r_buf_full && !w_reload);

      w_rx_word   = {r_rx_shift, w_mosi_sync};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_rx_shift    <= '0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_frame_abort <= 1'b0;
         r_tx_shift    <= '0;
         r_miso        <= 1'b0;
         r_buf         <= '0;
         r_buf_full    <= 1'b0;
         r_tx_ready    <= 1'b0;
         r_tx_underrun <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_frame_abort <= 1'b0;
         r_tx_underrun <= 1'b0;

         r_buf_full    <= w_full_next;
         r_tx_ready    <= !w_full_next;
         if (w_accept) begin
            r_buf <= bus.tx_data;
         end

         if (w_reload) begin
            r_tx_shift    <= w_load_word;
            r_tx_underrun <= !r_buf_full;
         end

         // MISO follows the shift MSB one clk later; forced low outside a frame.
         r_miso <= (r_state == ST_ACTIVE) && r_tx_shift[DATA_W-1];

         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall_evt) begin
                  r_state       <= ST_ACTIVE;
                  r_bit_cnt     <= '0;
                  r_frame_start <= 1'b1;
               end
            end

            ST_ACTIVE: begin
               if (w_cs_rise_evt) begin
                  // Partial word and pending shift contents are dropped; the
                  // holding buffer keeps whatever it has.
                  r_state       <= ST_IDLE;
                  r_frame_end   <= 1'b1;
                  r_frame_abort <= (r_bit_cnt != '0);
                  r_bit_cnt     <= '0;
                  r_tx_shift    <= '0;
                  r_miso        <= 1'b0;
               end else begin
                  if (w_sck_rise_evt) begin
                     r_rx_shift <= w_rx_word[DATA_W-2:0];
                     if (r_bit_cnt == c_LAST_BIT) begin
                        r_rx_data  <= w_rx_word;
                        r_rx_valid <= 1'b1;
                        r_bit_cnt  <= '0;
                     end else begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                     end
                  end
                  if (w_sck_fall_evt && (r_bit_cnt != '0)) begin
                     r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ----------------------------------------------------------- outputs
   assign bus.miso        = r_miso;
   assign bus.rx_data     = r_rx_data;
   assign bus.rx_valid    = r_rx_valid;
   assign bus.frame_start = r_frame_start;
   assign bus.frame_end   = r_frame_end;
   assign bus.frame_abort = r_frame_abort;
   assign bus.tx_ready    = r_tx_ready;
   assign bus.tx_underrun = r_tx_underrun;

endmodule : spi_byte_link
`default_nettype wire

// File: tb/tb_spi_byte_link.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_spi_byte_link                                                |
// | Purpose : Scoreboard bench for spi_byte_link. Stimulus tasks push the     |
// |           expected rx words, MISO bytes and frame events into queues;     |
// |           independent monitors pop and compare as the DUT presents them.  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_spi_byte_link;

   localparam int H = 8;   // clk cycles per SPI half period (spi_clk = clk/16)

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   spi_byte_link_if #(.DATA_W(8)) bus ();

   spi_byte_link #(
      .SYNC_STAGES (2),
      .DATA_W      (8),
      .IDLE_BYTE   (8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         n_tests   = 0;
   int         n_fail    = 0;
   int         under_cnt = 0;
   int         u0;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic       exp_start[$];
   logic       exp_end[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ------------------------------------------------ clk-domain monitor
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.rx_valid) begin
            chk("rx_valid_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) chk("rx_data", bus.rx_data, exp_rx.pop_front());
         end
         if (bus.frame_start) begin
            chk("frame_start_expected", exp_start.size() > 0, 1);
            if (exp_start.size() > 0) void'(exp_start.pop_front());
         end
         if (bus.frame_end) begin
            chk("frame_end_expected", exp_end.size() > 0, 1);
            if (exp_end.size() > 0) chk("frame_abort", bus.frame_abort, exp_end.pop_front());
         end
         if (bus.frame_abort && !bus.frame_end) chk("abort_without_end", 1, 0);
         if (bus.tx_underrun) under_cnt++;
      end
   end

   // ---------------------------------------- MISO monitor (master view)
   int         m_cnt = 0;
   logic [7:0] m_byte = 8'h00;

   always @(posedge bus.spi_clk or posedge bus.cs) begin
      if (bus.cs === 1'b1) begin
         m_cnt = 0;
         if (bus.spi_clk === 1'b1) chk("miso_idle", bus.miso, 0);
      end else begin
         m_byte = {m_byte[6:0], bus.miso};
         m_cnt++;
         if (m_cnt == 8) begin
            m_cnt = 0;
            chk("miso_expected", exp_miso.size() > 0, 1);
            if (exp_miso.size() > 0) chk("miso_byte", m_byte, exp_miso.pop_front());
         end
      end
   end

   // ---------------------------------------------------- stimulus tasks
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_begin();
      exp_start.push_back(1'b1);
      bus.cs = 1'b0;
      wait_clk(2*H);
   endtask

   task automatic spi_bit(input logic b);
      bus.mosi = b;
      wait_clk(H);
      bus.spi_clk = 1'b1;
      wait_clk(H);
      bus.spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] mo, input logic [7:0] mi);
      exp_rx.push_back(mo);
      exp_miso.push_back(mi);
      for (int i = 7; i >= 0; i--) spi_bit(mo[i]);
   endtask

   task automatic frame_stop(input logic abort);
      exp_end.push_back(abort);
      wait_clk(H);
      bus.cs = 1'b1;
      wait_clk(2*H);
   endtask

   task automatic tx_push(input logic [7:0] d);
      int n;
      n = 0;
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && n < 2000) begin
         wait_clk(1);
         n++;
      end
      chk("tx_accept", bus.tx_ready, 1);
      wait_clk(1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rx_data",     bus.rx_data,     0);
      chk("rst_rx_valid",    bus.rx_valid,    0);
      chk("rst_frame_start", bus.frame_start, 0);
      chk("rst_frame_end",   bus.frame_end,   0);
      chk("rst_frame_abort", bus.frame_abort, 0);
      chk("rst_miso",        bus.miso,        0);
      chk("rst_tx_ready",    bus.tx_ready,    0);
      chk("rst_tx_underrun", bus.tx_underrun, 0);
   endtask

   task automatic drain(input string tag);
      chk({tag, "_rx_left"},    exp_rx.size(),    0);
      chk({tag, "_miso_left"},  exp_miso.size(),  0);
      chk({tag, "_start_left"}, exp_start.size(), 0);
      chk({tag, "_end_left"},   exp_end.size(),   0);
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------- sequence
   initial begin
      bus.spi_clk  = 1'b0;
      bus.cs       = 1'b1;
      bus.mosi     = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      rst_n        = 1'b0;

      wait_clk(3);
      chk_reset_outputs();
      rst_n = 1'b1;
      wait_clk(3);
      chk("tx_ready_after_reset", bus.tx_ready, 1);

      // 1: single byte, empty buffer. Both the cs-fall load and the reload
      //    after the last falling edge find the buffer empty.
      u0 = under_cnt;
      frame_begin();
      spi_byte(8'hA5, 8'h00);
      frame_stop(1'b0);
      chk("t1_underruns", under_cnt - u0, 2);
      drain("t1");

      // 2: preloaded 3C then idle byte; the trailing reload underruns too.
      tx_push(8'h3C);
      u0 = under_cnt;
      frame_begin();
      spi_byte(8'h01, 8'h3C);
      spi_byte(8'h02, 8'h00);
      frame_stop(1'b0);
      chk("t2_underruns", under_cnt - u0, 2);
      drain("t2");

      // 3: abort after 5 bits, then a clean FF frame.
      u0 = under_cnt;
      frame_begin();
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      frame_stop(1'b1);
      frame_begin();
      spi_byte(8'hFF, 8'h00);
      frame_stop(1'b0);
      chk("t3_underruns", under_cnt - u0, 3);
      drain("t3");

      // 4: 11 offered while the old word 5A is being loaded for byte 0;
      //    22 then fills the buffer for the trailing reload.
      tx_push(8'h5A);
      u0 = under_cnt;
      fork
         begin
            frame_begin();
            spi_byte(8'hC3, 8'h5A);
            spi_byte(8'h3C, 8'h11);
            frame_stop(1'b0);
         end
         begin
            tx_push(8'h11);
            tx_push(8'h22);
         end
      join
      chk("t4_underruns", under_cnt - u0, 0);
      chk("t4_tx_ready", bus.tx_ready, 1);
      drain("t4");

      // 5: reset mid-byte with 69 sitting in the buffer; it must be lost.
      tx_push(8'h96);
      u0 = under_cnt;
      frame_begin();
      tx_push(8'h69);
      for (int i = 0; i < 4; i++) spi_bit(i[0]);
      wait_clk(2);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      chk("t5_underruns_pre_reset", under_cnt - u0, 0);
      bus.cs = 1'b1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(3);
      chk("t5_tx_ready", bus.tx_ready, 1);
      u0 = under_cnt;
      frame_begin();
      spi_byte(8'hE7, 8'h00);
      frame_stop(1'b0);
      chk("t5_underruns", under_cnt - u0, 2);
      drain("t5");

      // 6: spi_clk toggling with cs high is ignored.
      u0 = under_cnt;
      for (int i = 0; i < 16; i++) spi_bit(i[0]);
      wait_clk(2*H);
      chk("t6_underruns", under_cnt - u0, 0);
      drain("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_spi_byte_link
`default_nettype wire
